// File: rtl/gfx_fb_writer.sv
// Framebuffer writer: rgb24 stream -> two 16-bit Avalon-MM writes per pixel plus a mask set.
// Latency 2 cycles from beat accept to first write; in_ready drops only when the input FIFO is full.

module gfx_fb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             avail_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_vis_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    // The read side sees new entries one cycle after they are written (wr_vis_q),
    // while fullness uses the live write pointer so no entry is ever overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            wr_vis_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_vis_q <= wr_ptr_q;
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign avail_o   = (wr_vis_q != rd_ptr_q);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

module gfx_fb_writer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int GFX_LINEAR_RES = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_startofpacket,
    input  logic                              in_endofpacket,
    input  logic [23:0]                       in_data,
    input  logic                              fb_waitrequest,
    output logic                              fb_write,
    output logic [$clog2(GFX_LINEAR_RES):0]   fb_address,
    output logic [15:0]                       fb_writedata,
    output logic                              mask_write,
    output logic [$clog2(GFX_LINEAR_RES)-1:0] mask_addr,
    output logic                              frame_done,
    output logic                              sync_error,
    input  logic                              clear_error
);
    localparam int LIN_W = $clog2(GFX_LINEAR_RES);

    typedef logic [LIN_W-1:0] linear_coord_t;
    typedef logic [LIN_W:0]   half_coord_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [23:0] rgb;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    localparam linear_coord_t LAST_IDX = linear_coord_t'(GFX_LINEAR_RES - 1);

    state_t        state_q;
    logic [23:0]   pix_q;
    logic          eop_q;
    linear_coord_t cur_q;
    linear_coord_t pos_q;
    logic          fb_write_q;
    half_coord_t   fb_address_q;
    logic [15:0]   fb_writedata_q;
    logic          frame_done_q;
    logic          sync_error_q;

    beat_t         push_dat;
    beat_t         pop_dat;
    logic          fifo_full;
    logic          fifo_avail;
    logic          fifo_push;
    logic          fifo_pop;
    logic          lo_acc;
    logic          hi_acc;
    logic          cur_is_last;
    linear_coord_t pos_after;
    linear_coord_t cur_d;

    assign push_dat  = '{sop: in_startofpacket, eop: in_endofpacket, rgb: in_data};
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;

    gfx_fb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_dat_i (push_dat),
        .full_o     (fifo_full),
        .pop_i      (fifo_pop),
        .pop_dat_o  (pop_dat),
        .avail_o    (fifo_avail)
    );

    assign lo_acc      = (state_q == LO) && !fb_waitrequest;
    assign hi_acc      = (state_q == HI) && !fb_waitrequest;
    assign fifo_pop    = fifo_avail && ((state_q == IDLE) || hi_acc);
    assign cur_is_last = (cur_q == LAST_IDX);
    assign pos_after   = cur_is_last ? '0 : cur_q + 1'b1;

    // A pop on the HI accept must index from the position this very accept produces.
    always_comb begin
        cur_d = hi_acc ? pos_after : pos_q;
        if (pop_dat.sop) begin
            cur_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pix_q          <= '0;
            eop_q          <= 1'b0;
            cur_q          <= '0;
            pos_q          <= '0;
            fb_write_q     <= 1'b0;
            fb_address_q   <= '0;
            fb_writedata_q <= '0;
            frame_done_q   <= 1'b0;
            sync_error_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (hi_acc) begin
                pos_q        <= pos_after;
                frame_done_q <= cur_is_last;
            end

            if (hi_acc && (eop_q != cur_is_last)) begin
                sync_error_q <= 1'b1;
            end else if (clear_error) begin
                sync_error_q <= 1'b0;
            end

            if (fifo_pop) begin
                state_q        <= LO;
                pix_q          <= pop_dat.rgb;
                eop_q          <= pop_dat.eop;
                cur_q          <= cur_d;
                fb_write_q     <= 1'b1;
                fb_address_q   <= {cur_d, 1'b0};
                fb_writedata_q <= pop_dat.rgb[15:0];
            end else begin
                case (state_q)
                    LO: begin
                        if (lo_acc) begin
                            state_q        <= HI;
                            fb_address_q   <= {cur_q, 1'b1};
                            fb_writedata_q <= {8'h00, pix_q[23:16]};
                        end
                    end
                    HI: begin
                        if (hi_acc) begin
                            state_q    <= IDLE;
                            fb_write_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign fb_write     = fb_write_q;
    assign fb_address   = fb_address_q;
    assign fb_writedata = fb_writedata_q;
    assign mask_write   = hi_acc;
    assign mask_addr    = cur_q;
    assign frame_done   = frame_done_q;
    assign sync_error   = sync_error_q;

endmodule

// File: tb/tb_gfx_fb_writer.sv
// Randomized scoreboard bench for gfx_fb_writer against a per-pixel reference model.
module tb_gfx_fb_writer;
    localparam int RES   = 32;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(RES);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_startofpacket;
    logic          in_endofpacket;
    logic [23:0]   in_data;
    logic          fb_waitrequest;
    logic          fb_write;
    logic [AW:0]   fb_address;
    logic [15:0]   fb_writedata;
    logic          mask_write;
    logic [AW-1:0] mask_addr;
    logic          frame_done;
    logic          sync_error;
    logic          clear_error;

    gfx_fb_writer #(
        .FIFO_DEPTH     (DEPTH),
        .GFX_LINEAR_RES (RES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_data          (in_data),
        .fb_waitrequest   (fb_waitrequest),
        .fb_write         (fb_write),
        .fb_address       (fb_address),
        .fb_writedata     (fb_writedata),
        .mask_write       (mask_write),
        .mask_addr        (mask_addr),
        .frame_done       (frame_done),
        .sync_error       (sync_error),
        .clear_error      (clear_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cur;
        logic [23:0] pix;
        bit          fd;
        bit          set;
    } rec_t;

    rec_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          model_pos = 0;
    bit          err_model = 1'b0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          gap_base = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          fd_seen = 0;
    int          wait_mode = 0;
    logic [15:0] img [2*RES];
    logic [23:0] ref_img [RES];
    bit          ref_vld [RES];

    bit          lo_done = 1'b0;
    bit          prev_hi = 1'b0;
    bit          prev_fd = 1'b0;
    bit          prev_clr = 1'b0;
    bit          prev_stall = 1'b0;
    logic [AW:0] prev_addr;
    logic [15:0] prev_dat;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: pixel index from sop/position, two halves, mask, framing rules.
    function automatic void model_accept(input bit sop, input bit eop, input logic [23:0] pix);
        rec_t r;
        r.cur = sop ? 0 : model_pos;
        r.pix = pix;
        r.fd  = (r.cur == RES - 1);
        r.set = (eop != (r.cur == RES - 1));
        model_pos = (r.cur == RES - 1) ? 0 : r.cur + 1;
        ref_img[r.cur] = pix;
        ref_vld[r.cur] = 1'b1;
        exp_q.push_back(r);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (wait_mode)
            1:       fb_waitrequest = ($urandom_range(0, 1) == 1);
            2:       fb_waitrequest = 1'b1;
            default: fb_waitrequest = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            lo_done    = 1'b0;
            prev_hi    = 1'b0;
            prev_clr   = 1'b0;
            prev_stall = 1'b0;
            err_model  = 1'b0;
        end else begin
            if (prev_hi) begin
                chk("frame_done", frame_done, prev_fd);
                chk("sync_error", sync_error, err_model);
            end else begin
                if (frame_done) chk("frame_done_spurious", frame_done, 0);
                if (prev_clr) chk("sync_error_clear", sync_error, err_model);
            end
            if (frame_done) fd_seen++;
            if (prev_stall) begin
                chk("stall_write", fb_write, 1);
                chk("stall_addr", fb_address, prev_addr);
                chk("stall_data", fb_writedata, prev_dat);
            end
            prev_hi  = 1'b0;
            prev_clr = 1'b0;
            if (fb_write && !fb_waitrequest) begin
                acc_cnt++;
                if (acc_cnt == gap_base + 1) first_cyc = cyc;
                last_cyc = cyc;
                img[fb_address] = fb_writedata;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", fb_address, '1);
                end else if (!lo_done) begin
                    chk("lo_addr", fb_address, 32'(2 * exp_q[0].cur));
                    chk("lo_data", fb_writedata, exp_q[0].pix[15:0]);
                    chk("lo_mask_write", mask_write, 0);
                    lo_done = 1'b1;
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    chk("hi_addr", fb_address, 32'(2 * r.cur + 1));
                    chk("hi_data", fb_writedata, {8'h00, r.pix[23:16]});
                    chk("hi_mask_write", mask_write, 1);
                    chk("hi_mask_addr", mask_addr, r.cur);
                    lo_done   = 1'b0;
                    prev_hi   = 1'b1;
                    prev_fd   = r.fd;
                    err_model = r.set ? 1'b1 : (clear_error ? 1'b0 : err_model);
                end
            end
            if (!prev_hi) begin
                if (mask_write) chk("mask_without_accept", mask_write, 0);
                if (clear_error) begin
                    err_model = 1'b0;
                    prev_clr  = 1'b1;
                end
            end
            prev_stall = fb_write && fb_waitrequest;
            prev_addr  = fb_address;
            prev_dat   = fb_writedata;
        end
    end

    task automatic send(input bit sop, input bit eop, input logic [23:0] d);
        int n = 0;
        in_valid         = 1'b1;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_data          = d;
        while (!in_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", in_ready, 1);
        if (in_ready) begin
            @(posedge clk);
            model_accept(sop, eop, d);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_fb_write"}, fb_write, 0);
        chk({tag, "_fb_address"}, fb_address, 0);
        chk({tag, "_fb_writedata"}, fb_writedata, 0);
        chk({tag, "_mask_write"}, mask_write, 0);
        chk({tag, "_mask_addr"}, mask_addr, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_sync_error"}, sync_error, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        int n;
        rst_n            = 1'b0;
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_data          = '0;
        clear_error      = 1'b0;
        fb_waitrequest   = 1'b0;
        for (int i = 0; i < RES; i++) ref_vld[i] = 1'b0;

        #12;
        check_outputs_zero("reset");
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single pixel with latency probe, then a follow-on pixel to index 1.
        send(1'b1, 1'b0, 24'hA1B2C3);
        chk("latency_t0", fb_write, 0);
        @(posedge clk); #1;
        chk("latency_t1", fb_write, 0);
        @(posedge clk); #1;
        chk("latency_t2", fb_write, 1);
        drain();
        send(1'b0, 1'b0, 24'($urandom));
        drain();

        // Full frame back to back.
        gap_base = acc_cnt;
        fd0      = fd_seen;
        for (int i = 0; i < RES; i++) begin
            send(i == 0, i == RES - 1, 24'($urandom));
        end
        drain();
        chk("frame_writes", acc_cnt - gap_base, 2 * RES);
        chk("frame_no_gaps", last_cyc - first_cyc, 2 * RES - 1);
        chk("frame_done_count", fd_seen - fd0, 1);
        chk("frame_sync_error", sync_error, 0);

        // sop arriving mid-frame at position 7.
        send(1'b1, 1'b0, 24'($urandom));
        for (int i = 1; i < 7; i++) send(1'b0, 1'b0, 24'($urandom));
        send(1'b1, 1'b0, 24'($urandom));
        send(1'b0, 1'b0, 24'($urandom));
        drain();

        // Early eop at index 5, then clear.
        fd0 = fd_seen;
        send(1'b1, 1'b0, 24'($urandom));
        for (int i = 1; i < 5; i++) send(1'b0, 1'b0, 24'($urandom));
        send(1'b0, 1'b1, 24'($urandom));
        drain();
        chk("early_eop_sync_error", sync_error, 1);
        chk("early_eop_no_frame_done", fd_seen - fd0, 0);
        clear_error = 1'b1;
        @(posedge clk); #1;
        clear_error = 1'b0;
        chk("clear_error", sync_error, 0);

        // Backpressure: stall the slave and fill the FIFO behind the held pixel.
        wait_mode = 2;
        send(1'b0, 1'b0, 24'($urandom));
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("in_ready_before_full", in_ready, 1);
            send(1'b0, 1'b0, 24'($urandom));
        end
        chk("in_ready_full", in_ready, 0);
        wait_mode = 0;
        drain();

        // Random traffic under 50% waitrequest.
        wait_mode = 1;
        for (int i = 0; i < 300; i++) begin
            bit sop;
            bit eop;
            sop = ($urandom_range(0, 15) == 0);
            if (model_pos == RES - 1) eop = ($urandom_range(0, 7) != 0);
            else eop = ($urandom_range(0, 31) == 0);
            send(sop, eop, 24'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
            end
        end
        wait_mode = 0;
        drain();
        for (int i = 0; i < RES; i++) begin
            if (ref_vld[i]) begin
                chk("image_lo", img[2*i], ref_img[i][15:0]);
                chk("image_hi", img[2*i+1], {8'h00, ref_img[i][23:16]});
            end
        end

        // Reset during a stalled HI write.
        wait_mode = 2;
        send(1'b0, 1'b0, 24'($urandom));
        n = 0;
        while (!fb_write && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_lo_reached", fb_write, 1);
        wait_mode = 0;
        @(posedge clk); #1;
        wait_mode = 2;
        #2;
        chk("rst_hi_stalled_addr_bit", fb_address[0], 1);
        chk("rst_hi_stalled_write", fb_write, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        model_pos = 0;
        wait_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(1'b0, 1'b0, 24'($urandom));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
